// File: rtl/motor_pkg.sv
// motor_pkg: shared state encoding and direction constants for the shuttle sequencer
package motor_pkg;
    typedef enum logic [2:0] {IDLE, FWD, DW_END, BWD, DW_HOME, FAULT} seq_state_t;
    localparam logic FW = 1'b1;
    localparam logic BW = 1'b0;
endpackage

// File: rtl/ir_edge_sync.sv
// ir_edge_sync: per-bit 2-flop synchronizer with rise/fall pulse generation
module ir_edge_sync #(
    parameter int N = 2
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] rise_o,
    output logic [N-1:0] fall_o
);
    logic [N-1:0] meta_q, sync_q, prev_q;
    // Sensors idle high, so reset to ones keeps reset release from faking a fall
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            meta_q <= '1;
            sync_q <= '1;
            prev_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end
    assign rise_o = ~prev_q & sync_q;
    assign fall_o = prev_q & ~sync_q;
endmodule

// File: rtl/shuttle_sequencer.sv
// shuttle_sequencer: runs home-end-home shuttle cycles with dwell pauses and a travel watchdog
module shuttle_sequencer
    import motor_pkg::*;
#(
    parameter int DWELL   = 1000,
    parameter int TIMEOUT = 1_000_000,
    parameter int TO_W    = 20,
    parameter int CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic [CNT_W-1:0] num_cycles,
    input  logic             ir_home,
    input  logic             ir_end,
    output logic             dir,
    output logic             en,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [CNT_W-1:0] cycles_done
);
    localparam logic [TO_W-1:0] DW_LAST = TO_W'(DWELL - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    seq_state_t       state_q, state_d;
    logic [TO_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0] num_q, num_d, cyc_q, cyc_d, cyc_inc, req_num_q;
    logic             start_q;
    logic             dir_q, dir_d, en_q, en_d, busy_q, busy_d, done_q, done_d, fault_q, fault_d;
    logic [1:0]       fall, rise_unused;
    logic             end_fall, home_fall;

    ir_edge_sync #(.N(2)) u_sync (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .d_i    ({ir_end, ir_home}),
        .rise_o (rise_unused),
        .fall_o (fall)
    );

    assign end_fall  = fall[1];
    assign home_fall = fall[0];

    // Next state: stop overrides everything, sensor edge beats watchdog expiry
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        cyc_d   = cyc_q;
        done_d  = 1'b0;
        cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;
        case (state_q)
            IDLE: if (start_q && req_num_q != '0) begin
                state_d = FWD;
                num_d   = req_num_q;
                cyc_d   = '0;
            end
            FWD: state_d = end_fall ? DW_END : (cnt_q == TO_LAST) ? FAULT : FWD;
            DW_END: state_d = (cnt_q == DW_LAST) ? BWD : DW_END;
            BWD: if (home_fall) begin
                cyc_d   = cyc_inc;
                done_d  = (cyc_inc == num_q);
                state_d = done_d ? IDLE : DW_HOME;
            end else if (cnt_q == TO_LAST) begin
                state_d = FAULT;
            end
            DW_HOME: state_d = (cnt_q == DW_LAST) ? FWD : DW_HOME;
            FAULT: state_d = clear ? IDLE : FAULT;
            default: state_d = IDLE;
        endcase
        if (stop && busy_q) begin
            state_d = IDLE;
            cyc_d   = cyc_q;
            done_d  = 1'b0;
        end
        cnt_d   = (state_d == state_q && busy_q) ? cnt_q + 1'b1 : '0;
        dir_d   = (state_d == FWD) ? FW : (state_d == BWD) ? BW : dir_q;
        en_d    = (state_d == FWD) || (state_d == BWD);
        busy_d  = !((state_d == IDLE) || (state_d == FAULT));
        fault_d = (state_d == FAULT);
    end

    // State, shared dwell/watchdog counter and registered outputs
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            num_q     <= '0;
            cyc_q     <= '0;
            start_q   <= 1'b0;
            req_num_q <= '0;
            dir_q     <= FW;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            num_q     <= num_d;
            cyc_q     <= cyc_d;
            start_q   <= start;
            req_num_q <= num_cycles;
            dir_q     <= dir_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            fault_q   <= fault_d;
        end
    end

    assign dir         = dir_q;
    assign en          = en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fault       = fault_q;
    assign cycles_done = cyc_q;
endmodule
